// File: rtl/seq_mult_4x4_if.sv
// seq_mult_4x4_if
// Start/done handshake and operand/result bus for the sequential 4x4 multiplier.
//   start  - request, honoured only while the multiplier is idle
//   a, b   - 4-bit unsigned operands, captured on the accepting edge
//   ready  - multiplier idle, a start will be accepted
//   busy   - multiplier computing
//   done   - one-cycle pulse when p holds a fresh product
//   p      - 8-bit registered product, held until the next result
// master: the requester (test harness / control FSM); slave: the multiplier.
interface seq_mult_4x4_if;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] p;

    modport master (
        output start, a, b,
        input  ready, busy, done, p
    );

    modport slave (
        input  start, a, b,
        output ready, busy, done, p
    );
endinterface

// File: rtl/seq_mult_4x4.sv
// seq_mult_4x4
// Sequential 4x4 unsigned shift-and-add multiplier. A single 4-bit
// ripple-carry adder is reused every cycle to add one partial-product row
// into a shifting accumulator, giving a fixed 4-cycle compute latency.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - seq_mult_4x4_if slave: start/a/b in, ready/busy/done/p out
module seq_mult_4x4 (
    input  logic          clk,
    input  logic          rst_n,
    seq_mult_4x4_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     next_state;

    logic [3:0] m;
    logic [3:0] acc;
    logic [3:0] q;
    logic [1:0] cnt;
    logic [7:0] p_reg;

    logic [3:0] add_y;
    logic [3:0] add_s;
    logic [4:0] carry;
    logic       add_cout;
    logic [7:0] shifted;

    // The one arithmetic element: 4-bit ripple-carry adder computing
    // acc + (q[0] ? m : 0) with carry-in tied low.
    always_comb begin
        add_y    = q[0] ? m : 4'b0000;
        add_s    = 4'b0000;
        carry    = 5'b00000;
        carry[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            add_s[i]     = acc[i] ^ add_y[i] ^ carry[i];
            carry[i + 1] = (acc[i] & add_y[i]) | (carry[i] & (acc[i] ^ add_y[i]));
        end
        add_cout = carry[4];
    end

    // {cout, sum, q} shifted right by one with the LSB dropped. Keeping cout
    // as the new MSB is what makes large products (e.g. 15*15) come out right.
    assign shifted = {add_cout, add_s, q[3:1]};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: start only matters in IDLE, DONE always returns to IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (bus.start) next_state = CALC;
            CALC: if (cnt == 2'd3) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: operands load on the accepting edge, four shift-add steps
    // follow, and the product register only updates on the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m     <= 4'h0;
            acc   <= 4'h0;
            q     <= 4'h0;
            cnt   <= 2'd0;
            p_reg <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        m   <= bus.a;
                        q   <= bus.b;
                        acc <= 4'h0;
                        cnt <= 2'd0;
                    end
                end
                CALC: begin
                    acc <= shifted[7:4];
                    q   <= shifted[3:0];
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        p_reg <= shifted;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake outputs are decoded purely from the registered state.
    assign bus.ready = (state == IDLE);
    assign bus.busy  = (state == CALC);
    assign bus.done  = (state == DONE);
    assign bus.p     = p_reg;

endmodule

// File: tb/tb_seq_mult_4x4.sv
// tb_seq_mult_4x4
// Self-checking bench for seq_mult_4x4: a table of directed products, then
// hand-written sequences for product hold, ignored start, mid-operation
// reset, back-to-back start and an exhaustive sweep of all operand pairs.
module tb_seq_mult_4x4;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    int vectors     = 0;
    int miscompares = 0;
    int done_total  = 0;

    seq_mult_4x4_if bus();

    seq_mult_4x4 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Count every done pulse seen away from the active edge.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            done_total++;
        end
    end

    // Safety net so the run can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Run one multiply from an IDLE negedge to the following IDLE negedge,
    // checking latency, busy length, one-hot status and the product.
    task automatic applyStimulus(input logic [3:0] a_in, input logic [3:0] b_in,
                                 input logic [7:0] exp_p, input string tag);
        int   n;
        int   busy_n;
        logic excl_ok;
        checkOutput({tag, " ready before"}, 16'(bus.ready), 16'd1);
        bus.a     = a_in;
        bus.b     = b_in;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n       = 0;
        busy_n  = 0;
        excl_ok = 1'b1;
        while (!bus.done && n < 20) begin
            if (bus.busy) busy_n++;
            if ($countones({bus.ready, bus.busy, bus.done}) != 1) excl_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " latency"}, 16'(n), 16'd4);
        checkOutput({tag, " busy cycles"}, 16'(busy_n), 16'd4);
        checkOutput({tag, " one-hot"}, 16'(excl_ok), 16'd1);
        checkOutput({tag, " p"}, 16'(bus.p), 16'(exp_p));
        @(negedge clk);
        checkOutput({tag, " ready after"}, 16'(bus.ready), 16'd1);
        checkOutput({tag, " done after"}, 16'(bus.done), 16'd0);
    endtask

    initial begin
        vec_t table_v[11];
        int   snap;
        int   d;
        int   n;
        int   ready_cnt;

        table_v[0]  = '{a: 4'd15, b: 4'd15, p: 8'hE1};
        table_v[1]  = '{a: 4'd9,  b: 4'd6,  p: 8'h36};
        table_v[2]  = '{a: 4'd0,  b: 4'd13, p: 8'h00};
        table_v[3]  = '{a: 4'd3,  b: 4'd5,  p: 8'h0F};
        table_v[4]  = '{a: 4'd7,  b: 4'd7,  p: 8'h31};
        table_v[5]  = '{a: 4'd12, b: 4'd11, p: 8'h84};
        table_v[6]  = '{a: 4'd1,  b: 4'd1,  p: 8'h01};
        table_v[7]  = '{a: 4'd15, b: 4'd0,  p: 8'h00};
        table_v[8]  = '{a: 4'd8,  b: 4'd8,  p: 8'h40};
        table_v[9]  = '{a: 4'd15, b: 4'd1,  p: 8'h0F};
        table_v[10] = '{a: 4'd10, b: 4'd10, p: 8'h64};

        // Reset state.
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = 4'd0;
        bus.b     = 4'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset ready", 16'(bus.ready), 16'd1);
        checkOutput("reset busy", 16'(bus.busy), 16'd0);
        checkOutput("reset done", 16'(bus.done), 16'd0);
        checkOutput("reset p", 16'(bus.p), 16'h00);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table.
        for (int i = 0; i < 11; i++) begin
            applyStimulus(table_v[i].a, table_v[i].b, table_v[i].p, "table");
        end

        // 9*6, then 0*13 while checking that 0x36 is held until the next done.
        applyStimulus(4'd9, 4'd6, 8'h36, "hold first");
        bus.a     = 4'd0;
        bus.b     = 4'd13;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput("hold p during calc", 16'(bus.p), 16'h36);
            @(negedge clk);
        end
        checkOutput("hold done", 16'(bus.done), 16'd1);
        checkOutput("hold new p", 16'(bus.p), 16'h00);
        @(negedge clk);

        // start and operand changes during CALC and DONE are ignored.
        snap      = done_total;
        bus.a     = 4'd7;
        bus.b     = 4'd7;
        bus.start = 1'b1;
        @(negedge clk);
        bus.a = 4'd1;
        bus.b = 4'd1;
        n     = 0;
        while (!bus.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ignore latency", 16'(n), 16'd4);
        checkOutput("ignore p", 16'(bus.p), 16'h31);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("ignore single done", 16'(done_total - snap), 16'd1);
        checkOutput("ignore ready", 16'(bus.ready), 16'd1);

        // Reset two CALC edges into 12*11 aborts the operation.
        bus.a     = 4'd12;
        bus.b     = 4'd11;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abort ready", 16'(bus.ready), 16'd1);
        checkOutput("abort busy", 16'(bus.busy), 16'd0);
        checkOutput("abort done", 16'(bus.done), 16'd0);
        checkOutput("abort p", 16'(bus.p), 16'h00);
        snap = done_total;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("abort no done", 16'(done_total - snap), 16'd0);
        applyStimulus(4'd12, 4'd11, 8'h84, "after abort");

        // start held high: results repeat with exactly one ready cycle between.
        bus.a     = 4'd3;
        bus.b     = 4'd5;
        bus.start = 1'b1;
        d         = 0;
        n         = 0;
        ready_cnt = 0;
        while (d < 3 && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.done) begin
                d++;
                checkOutput("held start p", 16'(bus.p), 16'h0F);
            end
            if (d > 0 && bus.ready) ready_cnt++;
        end
        bus.start = 1'b0;
        checkOutput("held start dones", 16'(d), 16'd3);
        checkOutput("held start ready cycles", 16'(ready_cnt), 16'd2);
        @(negedge clk);

        // Exhaustive sweep of every operand pair.
        snap = done_total;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                applyStimulus(4'(ai), 4'(bi), 8'(ai * bi), "exhaustive");
            end
        end
        checkOutput("exhaustive done count", 16'(done_total - snap), 16'd256);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
